// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of the FIFO write port: bursts of len+1 words, grant 1 cycle after req, one idle bubble per burst.
// Stalls on full with push=!full; WRARB_TIMEOUT_EN adds a stall timeout that aborts the burst.
module fifo_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int DWIDTH   = 8,
   parameter int LENWIDTH = 4
`ifdef WRARB_TIMEOUT_EN
   ,
   parameter int TMO      = 16
`endif
) (
   input  logic                     wclk,
   input  logic                     reset_L,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*LENWIDTH-1:0] req_len,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   input  logic                     full,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          take,
   output logic                     push,
   output logic [DWIDTH-1:0]        wdata,
   output logic                     busy,
   output logic                     abort
);

   localparam int RRW = $clog2(NREQ);

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [LENWIDTH-1:0] cnt_q, cnt_d;
   logic [RRW-1:0]      rr_last_q, rr_last_d;
   logic [RRW-1:0]      sel;
   logic                sel_vld;
   logic [LENWIDTH-1:0] len_sel;

`ifdef WRARB_TIMEOUT_EN
   localparam int SW = $clog2(TMO) + 1;
   logic [SW-1:0]       stall_q, stall_d;
   logic                abort_q, abort_d;
   assign abort = abort_q;
`else
   assign abort = 1'b0;
`endif

   assign busy = (state_q == BURST);
   assign push = busy & ~full;
   assign take = gnt_q & {NREQ{push}};
   assign gnt  = gnt_q;

   // Lowest requester above rr_last wins; otherwise wrap to the lowest overall.
   always_comb begin
      sel_vld = 1'b0;
      sel     = '0;
      len_sel = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel     = RRW'(i);
            sel_vld = 1'b1;
         end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i] && (RRW'(i) > rr_last_q)) begin
            sel = RRW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (sel == RRW'(i)) begin
            len_sel = req_len[i*LENWIDTH +: LENWIDTH];
         end
      end
   end

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         wdata = wdata | (req_data[i*DWIDTH +: DWIDTH] & {DWIDTH{gnt_q[i]}});
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      rr_last_d = rr_last_q;
`ifdef WRARB_TIMEOUT_EN
      abort_d   = 1'b0;
      stall_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               state_d   = BURST;
               cnt_d     = len_sel;
               rr_last_d = sel;
               for (int i = 0; i < NREQ; i++) begin
                  gnt_d[i] = (sel == RRW'(i));
               end
            end
         end
         BURST: begin
            if (push) begin
               if (cnt_q == '0) begin
                  gnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
`ifdef WRARB_TIMEOUT_EN
            // Not pushing in BURST means full is high: count the stall.
            else if (stall_q == SW'(TMO - 1)) begin
               gnt_d   = '0;
               state_d = IDLE;
               abort_d = 1'b1;
            end else begin
               stall_d = stall_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!reset_L) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         cnt_q     <= '0;
         rr_last_q <= RRW'(NREQ - 1);
`ifdef WRARB_TIMEOUT_EN
         stall_q   <= '0;
         abort_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         rr_last_q <= rr_last_d;
`ifdef WRARB_TIMEOUT_EN
         stall_q   <= stall_d;
         abort_q   <= abort_d;
`endif
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the async FIFO write port among NREQ requesters in the write clock domain.
- Grants one requester at a time for a burst of (len+1) words.
- Drives push/wdata into the write-side controller and stalls on its full flag.
- Sits between client write engines and the FIFO write controller plus memory write port.

Parameters:
NREQ, 4, number of requesters (2..8)
DWIDTH, 8, data word width
LENWIDTH, 4, burst length field width; a burst is len+1 words (1..2^LENWIDTH)
TMO, 16, stall timeout in cycles; used only with the optional feature

Ports:
wclk  input  1  write-domain clock; all logic is on the rising edge
reset_L  input  1  reset, synchronous, active-low
req  input  NREQ  per-requester burst request, level
req_len  input  NREQ*LENWIDTH  packed burst length minus 1; requester i at [i*LENWIDTH +: LENWIDTH]
req_data  input  NREQ*DWIDTH  packed write data; requester i at [i*DWIDTH +: DWIDTH]
full  input  1  FIFO full flag from the write controller
gnt  output  NREQ  one-hot grant, registered
take  output  NREQ  one-hot per-word accept strobe; requester advances its data on take[i]
push  output  1  FIFO write strobe
wdata  output  DWIDTH  data of the granted requester
busy  output  1  burst in progress
abort  output  1  burst aborted by timeout, one-cycle pulse

Behaviour:
- Reset is sampled on the wclk edge when reset_L==0.
  - On reset: state=IDLE, gnt=0, cnt=0, rr_last=NREQ-1, abort=0.
  - Derived outputs are then 0: take=0, push=0, busy=0.
  - wdata=0 whenever gnt==0.
- Reset during a burst abandons the burst at that edge. No further push occurs; the partial burst is not completed.
- FSM states: IDLE and BURST.
- IDLE:
  - If |req, select the first asserted requester scanning (rr_last+1) mod NREQ upward, with wrap.
  - Next edge: gnt<=onehot(sel), cnt<=req_len[sel], rr_last<=sel, state<=BURST.
  - If no req, stay in IDLE.
- BURST:
  - busy=1.
  - push = !full (combinational; full is a registered-source flag, so no loop).
  - take = gnt & {NREQ{push}}.
  - wdata = req_data slice selected by gnt (AND-OR mux).
  - On an edge with push=1: if cnt==0, then gnt<=0 and state<=IDLE; otherwise cnt<=cnt-1.
  - On an edge with push=0: hold all state.
- Latency:
  - Grant is visible 1 cycle after req is sampled in IDLE.
  - First push can occur in that same cycle if full==0.
  - Every burst is followed by exactly one IDLE cycle (arbitration bubble). Maximum throughput is (len+1)/(len+2).
- req is not monitored during BURST. Dropping req mid-burst does not shorten the burst. The requester must supply data on every take until the burst ends.
- Simultaneous requests: strict round-robin relative to rr_last. After a grant to i, the lowest priority is i.
- A single requester holding req continuously is re-granted after each bubble.
- full asserted in the final word's cycle: the word is not taken and the burst stays open until full drops.
- len=all-ones gives 2^LENWIDTH words; cnt must not underflow.
- Never push while full==1. push is never asserted outside BURST.

Optional Feature:
- Macro: WRARB_TIMEOUT_EN.
- Defined:
  - A stall counter, width clog2(TMO)+1, increments on each BURST cycle with full==1 and clears on push or on leaving BURST.
  - When it reaches TMO-1 with full still 1, at the next edge: state<=IDLE, gnt<=0, abort<=1 for exactly one cycle, rr_last unchanged (the aborted requester keeps lowest priority).
  - Words already pushed stay in the FIFO. Remaining words are dropped.
- Undefined: no stall counter, abort tied to 0, the burst waits on full indefinitely.

Test Plan:
1. Reset, then req=4'b0001, len0=2, full=0 -> gnt=0001 on the next cycle; push high 3 consecutive cycles; take[0] x3; wdata follows req_data[7:0]; gnt=0 after 3 pushes; busy low 1 cycle.
2. req=4'b1111, all len=0, held 8 grants -> grant order 0,1,2,3,0,1,2,3; each grant gives 1 push then 1 bubble cycle.
3. Grant to 2 with len=3, full=1 on cycles 2-4 of the burst -> push=0 and cnt held during the stall; exactly 4 pushes total; no push while full=1.
4. len=15 (LENWIDTH=4) -> exactly 16 pushes; state returns to IDLE; no extra push from cnt wrap.
5. reset_L=0 for 1 cycle mid-burst after 2 of 5 words -> next cycle gnt=0, push=0, busy=0; the next arbitration starts from requester 0 (rr_last=NREQ-1).
6. With WRARB_TIMEOUT_EN and TMO=16, full held high from the 2nd word -> abort pulses once on the 16th stalled cycle; gnt=0; no further push for that burst. Without the macro -> abort stays 0 and the burst resumes when full drops.
